// File: rtl/mdu_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU sequencer driving a dedicated 32-bit ALU.
// Owns HI/LO and serves MTHI/MTLO; busy stalls decode while an operation runs.
module mdu_sequencer #(
    parameter logic [2:0]  ADD_CODE = 3'd0,
    parameter logic [2:0]  SUB_CODE = 3'd1,
    parameter int unsigned ITER     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = $clog2(ITER);

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [W-1:0]   opnd, opnd_n;
    logic           is_div, is_div_n;
    logic [W-1:0]   hi_n, lo_n;
    logic [W-1:0]   alu_a_n, alu_b_n;
    logic [2:0]     alu_ctrl_n;
    logic           busy_n, done_n;
    logic [W-1:0]   rem;
    logic           carry;

    // State and datapath registers; ALU drive is registered from next-state values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= ADD_CODE;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            opnd     <= opnd_n;
            is_div   <= is_div_n;
            hi       <= hi_n;
            lo       <= lo_n;
            alu_a    <= alu_a_n;
            alu_b    <= alu_b_n;
            alu_ctrl <= alu_ctrl_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Next-state, iteration step and ALU operand selection
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        opnd_n     = opnd;
        is_div_n   = is_div;
        hi_n       = hi;
        lo_n       = lo;
        alu_a_n    = '0;
        alu_b_n    = '0;
        alu_ctrl_n = ADD_CODE;
        rem        = {hi[W-2:0], lo[W-1]};
        carry      = (alu_result < hi);

        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MTHI: hi_n = rs_val;
                        OP_MTLO: lo_n = rs_val;
                        OP_MULTU: begin
                            opnd_n   = rs_val;
                            is_div_n = 1'b0;
                            hi_n     = '0;
                            lo_n     = rt_val;
                            cnt_n    = '0;
                            state_n  = CALC;
                        end
                        OP_DIVU: begin
                            opnd_n   = rt_val;
                            is_div_n = 1'b1;
                            hi_n     = '0;
                            lo_n     = rs_val;
                            cnt_n    = '0;
                            state_n  = CALC;
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (is_div) begin
                    // Restoring step: hi[31] is the bit shifted out of the 32-bit remainder
                    if (hi[W-1] || (rem >= opnd)) begin
                        hi_n = alu_result;
                        lo_n = {lo[W-2:0], 1'b1};
                    end else begin
                        hi_n = rem;
                        lo_n = {lo[W-2:0], 1'b0};
                    end
                end else begin
                    // Shift-add step: carry out of hi+addend recovered by wrap compare
                    hi_n = {carry, alu_result[W-1:1]};
                    lo_n = {alu_result[0], lo[W-1:1]};
                end
                if (cnt == CW'(ITER - 1)) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (state_n == CALC) begin
            if (is_div_n) begin
                alu_a_n    = {hi_n[W-2:0], lo_n[W-1]};
                alu_b_n    = opnd_n;
                alu_ctrl_n = SUB_CODE;
            end else begin
                alu_a_n    = hi_n;
                alu_b_n    = lo_n[0] ? opnd_n : '0;
                alu_ctrl_n = ADD_CODE;
            end
        end

        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer with a behavioural ALU model.
module tb_mdu_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] MULTU = 2'b00;
    localparam logic [1:0] DIVU  = 2'b01;
    localparam logic [1:0] MTHI  = 2'b10;
    localparam logic [1:0] MTLO  = 2'b11;

    mdu_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    // Owned ALU: 0 = add, 1 = subtract
    always_comb begin
        case (alu_ctrl)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            default: alu_result = 32'h0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns at the negedge after the accepting edge
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start  = 1'b0;
        op     = 2'($urandom);
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) busy_cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc, bc;
        issue(o, a, b);
        wait_done(cyc, bc);
        check({tag, "_latency"}, 32'(cyc), 32'd32);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        @(negedge clk);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc, bc, pulses;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        rs_val = 32'h0;
        rt_val = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_alu_a", alu_a, 32'h0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        reset = 1'b0;

        // Max multiply with detailed timing and ALU drive checks
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("mul_max_busy_rise", 32'(busy), 32'd1);
        check("mul_max_alu_a0", alu_a, 32'h0);
        check("mul_max_alu_b0", alu_b, 32'hFFFFFFFF);
        check("mul_max_alu_ctrl0", 32'(alu_ctrl), 32'd0);
        wait_done(cyc, bc);
        check("mul_max_latency", 32'(cyc), 32'd32);
        check("mul_max_busy_cycles", 32'(bc), 32'd33);
        check("mul_max_done", 32'(done), 32'd1);
        check("mul_max_hi", hi, 32'hFFFFFFFE);
        check("mul_max_lo", lo, 32'h00000001);
        check("mul_max_done_alu_a", alu_a, 32'h0);
        @(negedge clk);
        check("mul_max_done_fall", 32'(done), 32'd0);
        check("mul_max_busy_fall", 32'(busy), 32'd0);

        run_op("mul_zero", MULTU, 32'h00012345, 32'h0, 32'h0, 32'h0);
        run_op("mul_carry", MULTU, 32'h80000000, 32'h2, 32'h1, 32'h0);

        // Divide: first-iteration ALU drive uses subtract and the divisor
        issue(DIVU, 32'd100, 32'd7);
        check("div100_alu_a0", alu_a, 32'h0);
        check("div100_alu_b0", alu_b, 32'd7);
        check("div100_alu_ctrl0", 32'(alu_ctrl), 32'd1);
        wait_done(cyc, bc);
        check("div100_latency", 32'(cyc), 32'd32);
        check("div100_hi", hi, 32'd2);
        check("div100_lo", lo, 32'd14);
        @(negedge clk);

        run_op("div_big", DIVU, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF);
        run_op("div_zero", DIVU, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF);

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        start = 1'b1; op = MTHI; rs_val = 32'hDEADBEEF;
        @(negedge clk);
        check("mthi_hi", hi, 32'hDEADBEEF);
        check("mthi_busy", 32'(busy), 32'd0);
        check("mthi_done", 32'(done), 32'd0);
        op = MTLO; rs_val = 32'hCAFEF00D;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", lo, 32'hCAFEF00D);
        check("mtlo_hi_kept", hi, 32'hDEADBEEF);
        check("mtlo_busy", 32'(busy), 32'd0);
        check("mtlo_done", 32'(done), 32'd0);

        // Start while busy is ignored
        issue(MULTU, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        start = 1'b1; op = DIVU; rs_val = 32'd9; rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bc);
        check("ign_latency", 32'(cyc), 32'd27);
        check("ign_hi", hi, 32'h0);
        check("ign_lo", lo, 32'd15);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("ign_extra_done", 32'(pulses), 32'd0);
        check("ign_busy_low", 32'(busy), 32'd0);

        // Asynchronous reset mid-divide aborts the operation
        issue(DIVU, 32'h12345678, 32'd3);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_alu_ctrl", 32'(alu_ctrl), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("post_rst_mul", MULTU, 32'd6, 32'd7, 32'h0, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
